// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
// Main control FSM of the multi-cycle MIPS core. It sequences the shared ALU,
// register file, PC and unified memory port through FETCH / DECODE / EXECUTE /
// MEM / WB states. It traps on undecoded opcodes and on memory accesses that
// wait too long.
//
// Parameters
//   MEM_TIMEOUT   max wait cycles per memory state before trapping (0 = never)
//   ILLEGAL_TRAP  1: undecoded opcode traps, 0: undecoded opcode acts as a NOP
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   opcode           instr[31:26] from the instruction register
//   mem_ready        memory finishes the current read/write this cycle
//   pc_write, pc_write_cond, pc_source      PC update controls
//   i_or_d, mem_read, mem_write, ir_write, mdr_write   memory port controls
//   reg_dst, mem_to_reg, reg_write          register file controls
//   alu_src_a, alu_src_b, alu_op            ALU operand / operation select
//   instr_done       1-cycle pulse in the last state of every instruction
//   state            current state encoding (debug)
//   illegal_op       sticky: an illegal opcode was trapped
//   mem_timeout      sticky: a memory wait exceeded MEM_TIMEOUT
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT  = 255,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12,
        S_INIT   = 4'd13
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic               illegal_reg, timeout_reg;
    logic               ill_set, tmo_set;
    logic               in_wait_state, timeout_hit;

    assign state       = state_reg;
    assign illegal_op  = illegal_reg;
    assign mem_timeout = timeout_reg;

    assign in_wait_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                           (state_reg == S_MEMWR);

    // The wait that would push the counter up to MEM_TIMEOUT is the one that
    // traps; a ready on that same cycle still completes normally.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                         (int'(wait_cnt_reg) >= MEM_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_INIT;
            wait_cnt_reg <= '0;
            illegal_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            illegal_reg  <= illegal_reg | ill_set;
            timeout_reg  <= timeout_reg | tmo_set;
        end
    end

    // Staying in a wait state means the memory was not ready this cycle;
    // any other transition (including entry into a wait state) clears it.
    always_comb begin
        wait_cnt_next = '0;
        if (in_wait_state && (state_next == state_reg)) begin
            wait_cnt_next = (wait_cnt_reg == '1) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ill_set       = 1'b0;
        tmo_set       = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;

        case (state_reg)
            S_INIT: state_next = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;          // PC + 4
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                    tmo_set    = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;          // precompute branch target
                case (opcode)
                    6'b000000:           state_next = S_EXEC;
                    6'b100011, 6'b101011: state_next = S_MEMADR;
                    6'b000100:           state_next = S_BRANCH;
                    6'b000010:           state_next = S_JUMP;
                    6'b001000:           state_next = S_ADDIEX;
                    default: begin
                        if (ILLEGAL_TRAP) begin
                            state_next = S_TRAP;
                            ill_set    = 1'b1;
                        end else begin
                            state_next = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read  = 1'b1;
                i_or_d    = 1'b1;
                mdr_write = mem_ready;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                    tmo_set    = 1'b1;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                    tmo_set    = 1'b1;
                end
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_next    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_INIT;   // unused encodings recover via INIT
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Self-checking bench for mips_multicycle_ctrl. Two instances: one with
// MEM_TIMEOUT=4 / ILLEGAL_TRAP=1, one with MEM_TIMEOUT=0 / ILLEGAL_TRAP=0.
// Each cycle the expected output vector is pushed to a scoreboard queue when
// the inputs are driven, then popped and compared against the sampled outputs.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n, rst2_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       sel;

    always #5 clk = ~clk;

    logic       a_pc_write, a_pc_write_cond, a_i_or_d, a_mem_read, a_mem_write;
    logic       a_ir_write, a_mdr_write, a_reg_dst, a_mem_to_reg, a_reg_write;
    logic       a_alu_src_a, a_instr_done, a_illegal_op, a_mem_timeout;
    logic [1:0] a_alu_src_b, a_alu_op, a_pc_source;
    logic [3:0] a_state;

    logic       b_pc_write, b_pc_write_cond, b_i_or_d, b_mem_read, b_mem_write;
    logic       b_ir_write, b_mdr_write, b_reg_dst, b_mem_to_reg, b_reg_write;
    logic       b_alu_src_a, b_instr_done, b_illegal_op, b_mem_timeout;
    logic [1:0] b_alu_src_b, b_alu_op, b_pc_source;
    logic [3:0] b_state;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .ILLEGAL_TRAP(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond), .i_or_d(a_i_or_d),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .ir_write(a_ir_write),
        .mdr_write(a_mdr_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
        .reg_write(a_reg_write), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .alu_op(a_alu_op), .pc_source(a_pc_source), .instr_done(a_instr_done),
        .state(a_state), .illegal_op(a_illegal_op), .mem_timeout(a_mem_timeout)
    );

    mips_multicycle_ctrl #(.MEM_TIMEOUT(0), .ILLEGAL_TRAP(1'b0)) u_dut_nop (
        .clk(clk), .rst_n(rst2_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .i_or_d(b_i_or_d),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
        .mdr_write(b_mdr_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
        .reg_write(b_reg_write), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .alu_op(b_alu_op), .pc_source(b_pc_source), .instr_done(b_instr_done),
        .state(b_state), .illegal_op(b_illegal_op), .mem_timeout(b_mem_timeout)
    );

    logic [23:0] obs_a, obs_b, obs;
    assign obs_a = {a_state, a_pc_write, a_pc_write_cond, a_i_or_d, a_mem_read,
                    a_mem_write, a_ir_write, a_mdr_write, a_reg_dst, a_mem_to_reg,
                    a_reg_write, a_alu_src_a, a_alu_src_b, a_alu_op, a_pc_source,
                    a_instr_done, a_illegal_op, a_mem_timeout};
    assign obs_b = {b_state, b_pc_write, b_pc_write_cond, b_i_or_d, b_mem_read,
                    b_mem_write, b_ir_write, b_mdr_write, b_reg_dst, b_mem_to_reg,
                    b_reg_write, b_alu_src_a, b_alu_src_b, b_alu_op, b_pc_source,
                    b_instr_done, b_illegal_op, b_mem_timeout};
    assign obs = sel ? obs_b : obs_a;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        exp_ill = 1'b0;
    logic        exp_tmo = 1'b0;
    logic [23:0] exp_q[$];

    task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end else begin
            $display("txn %s ok %h", tag, got);
        end
    endtask

    // Expected outputs for a given state, straight from the state table.
    function automatic logic [23:0] exp_out(input logic [3:0] st, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, mdrw, rd, m2r, rw, sa, done;
        logic [1:0] sb, op, ps;
        {pw, pwc, iod, mr, mw, irw, mdrw, rd, m2r, rw, sa, done} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pw = rdy; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  begin mr = 1'b1; iod = 1'b1; mdrw = rdy; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
            4'd5:  begin mw = 1'b1; iod = 1'b1; done = rdy; end
            4'd6:  begin sa = 1'b1; op = 2'b10; end
            4'd7:  begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
            4'd8:  begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; done = 1'b1; end
            4'd9:  begin sa = 1'b1; sb = 2'b10; end
            4'd10: begin rw = 1'b1; done = 1'b1; end
            4'd11: begin pw = 1'b1; ps = 2'b10; done = 1'b1; end
            default: ;
        endcase
        return {st, pw, pwc, iod, mr, mw, irw, mdrw, rd, m2r, rw, sa, sb, op, ps,
                done, exp_ill, exp_tmo};
    endfunction

    task automatic observe(input logic [3:0] st, input logic rdy);
        logic [23:0] want;
        exp_q.push_back(exp_out(st, rdy));
        want = exp_q.pop_front();
        check_val($sformatf("dut%0d t=%0t st=%0d rdy=%0b", sel, $time, st, rdy), obs, want);
    endtask

    task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] st);
        @(negedge clk);
        opcode    = op;
        mem_ready = rdy;
        #1;
        observe(st, rdy);
    endtask

    // Assert reset (checked immediately, since it is asynchronous), hold it,
    // release it and confirm INIT is visible before the next clock edge.
    task automatic hold_reset(input bit which);
        if (which) rst2_n = 1'b0; else rst_n = 1'b0;
        exp_ill = 1'b0;
        exp_tmo = 1'b0;
        #1;
        observe(4'd13, mem_ready);
        step(OP_R, 1'b1, 4'd13);
        step(OP_R, 1'b0, 4'd13);
        if (which) rst2_n = 1'b1; else rst_n = 1'b1;
        #1;
        observe(4'd13, mem_ready);
    endtask

    initial begin
        rst_n     = 1'b1;
        rst2_n    = 1'b1;
        sel       = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        #2;
        rst2_n    = 1'b0;
        hold_reset(1'b0);

        // R-type: FETCH, DECODE, EXEC, ALUWB
        step(OP_R, 1, 0); step(OP_R, 1, 1); step(OP_R, 1, 6); step(OP_R, 1, 7);
        // LW with 3 wait cycles in MEMRD
        step(OP_LW, 1, 0); step(OP_LW, 1, 1); step(OP_LW, 1, 2);
        for (int i = 0; i < 3; i++) step(OP_LW, 0, 3);
        step(OP_LW, 1, 3); step(OP_LW, 1, 4);
        // SW, BEQ, J, ADDI
        step(OP_SW, 1, 0); step(OP_SW, 1, 1); step(OP_SW, 1, 2); step(OP_SW, 1, 5);
        step(OP_BEQ, 1, 0); step(OP_BEQ, 1, 1); step(OP_BEQ, 1, 8);
        step(OP_J, 1, 0); step(OP_J, 1, 1); step(OP_J, 1, 11);
        step(OP_ADDI, 1, 0); step(OP_ADDI, 1, 1); step(OP_ADDI, 1, 9); step(OP_ADDI, 1, 10);
        // Ready arrives on the 4th FETCH cycle: the timeout cycle completes normally
        for (int i = 0; i < 3; i++) step(OP_J, 0, 0);
        step(OP_J, 1, 0); step(OP_J, 1, 1); step(OP_J, 1, 11);
        // Four unready FETCH cycles -> TRAP with mem_timeout
        for (int i = 0; i < 4; i++) step(OP_J, 0, 0);
        exp_tmo = 1'b1;
        for (int i = 0; i < 4; i++) step(OP_J, 1'($urandom_range(0, 1)), 12);
        hold_reset(1'b0);

        // Counter restarts on MEMRD entry after FETCH waits; then times out there
        step(OP_LW, 0, 0); step(OP_LW, 0, 0); step(OP_LW, 1, 0);
        step(OP_LW, 1, 1); step(OP_LW, 1, 2);
        for (int i = 0; i < 4; i++) step(OP_LW, 0, 3);
        exp_tmo = 1'b1;
        step(OP_LW, 1, 12); step(OP_LW, 0, 12);
        hold_reset(1'b0);

        // Illegal opcode -> absorbing TRAP for 20 cycles
        step(OP_BAD, 1, 0); step(OP_BAD, 1, 1);
        exp_ill = 1'b1;
        for (int i = 0; i < 20; i++) step(OP_BAD, 1'($urandom_range(0, 1)), 12);
        hold_reset(1'b0);

        // Reset asserted while in MEMWR: outputs must drop immediately
        step(OP_SW, 1, 0); step(OP_SW, 1, 1); step(OP_SW, 1, 2);
        step(OP_SW, 0, 5); step(OP_SW, 0, 5);
        hold_reset(1'b0);
        step(OP_R, 1, 0); step(OP_R, 1, 1); step(OP_R, 1, 6); step(OP_R, 1, 7);

        // NOP-on-illegal instance with no timeout
        rst_n = 1'b0;
        sel   = 1'b1;
        hold_reset(1'b1);
        for (int i = 0; i < 8; i++) step(OP_BAD, 0, 0);
        step(OP_BAD, 1, 0); step(OP_BAD, 1, 1);
        step(OP_R, 1, 0); step(OP_R, 1, 1); step(OP_R, 1, 6); step(OP_R, 1, 7);
        step(OP_LW, 1, 0); step(OP_LW, 1, 1); step(OP_LW, 1, 2);
        for (int i = 0; i < 6; i++) step(OP_LW, 0, 3);
        step(OP_LW, 1, 3); step(OP_LW, 1, 4); step(OP_R, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
